// File: rtl/adder_sync_pkg.sv
// Shared constants for the registered ripple-carry adder: default width and
// the values the output registers take while reset is held.
package adder_sync_pkg;

  localparam int WIDTH_DEFAULT = 2;

  localparam logic SUM_RST_BIT = 1'b0;
  localparam logic CARRY_RST   = 1'b0;
  localparam logic OVF_RST     = 1'b0;
  localparam logic VLD_RST     = 1'b0;

  // Signed overflow of the MSB stage: its carry-in disagrees with its carry-out.
  function automatic logic ovf_from_carries(input logic cin_msb, input logic cout_msb);
    return cin_msb ^ cout_msb;
  endfunction

endpackage

// File: rtl/adder_sync_fa.sv
// One-bit full adder, the ripple cell of adder_synchronous.
module adder_sync_fa
  import adder_sync_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_synchronous.sv
// Registered WIDTH-bit unsigned adder with carry-out, signed overflow and valid.
// Defining ADDER_SYNC_INREG_EN adds an input register stage (latency 2 instead of 1).
module adder_synchronous
  import adder_sync_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum_reg,
  output logic             Carry_reg,
  output logic             Ovf_reg,
  output logic             Out_valid
);

  logic [WIDTH-1:0] a_add;
  logic [WIDTH-1:0] b_add;
  logic             vld_add;
  logic [WIDTH-1:0] sum_add;
  logic [WIDTH:0]   carry;

`ifdef ADDER_SYNC_INREG_EN
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             vld_p0;

  // Stage p0: operand capture; only the valid flag is reset
  always_ff @(posedge Clk) begin
    a_p0 <= A;
    b_p0 <= B;
  end

  always_ff @(posedge Clk) begin
    if (Rst) vld_p0 <= VLD_RST;
    else     vld_p0 <= 1'b1;
  end

  assign a_add   = a_p0;
  assign b_add   = b_p0;
  assign vld_add = vld_p0;
`else
  assign a_add   = A;
  assign b_add   = B;
  assign vld_add = 1'b1;
`endif

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    adder_sync_fa u_fa (
      .a    (a_add[i]),
      .b    (b_add[i]),
      .cin  (carry[i]),
      .s    (sum_add[i]),
      .cout (carry[i+1])
    );
  end

  // Output stage: result registers, cleared while reset is held
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Sum_reg   <= {WIDTH{SUM_RST_BIT}};
      Carry_reg <= CARRY_RST;
      Ovf_reg   <= OVF_RST;
      Out_valid <= VLD_RST;
    end else begin
      Sum_reg   <= sum_add;
      Carry_reg <= carry[WIDTH];
      Ovf_reg   <= ovf_from_carries(carry[WIDTH-1], carry[WIDTH]);
      Out_valid <= vld_add;
    end
  end

endmodule

// File: tb/tb_adder_synchronous.sv
// Scoreboard bench for adder_synchronous: expected results queued at drive time,
// popped once the pipeline latency has elapsed.
module tb_adder_synchronous;

  localparam int W = 2;
`ifdef ADDER_SYNC_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic         v;
    logic         c;
    logic         o;
    logic [W-1:0] s;
  } exp_t;

  logic         Clk;
  logic         Rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Sum_reg;
  logic         Carry_reg;
  logic         Ovf_reg;
  logic         Out_valid;

  exp_t sb[$];
  int   total;
  int   bad;

  adder_synchronous #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .A         (A),
    .B         (B),
    .Sum_reg   (Sum_reg),
    .Carry_reg (Carry_reg),
    .Ovf_reg   (Ovf_reg),
    .Out_valid (Out_valid)
  );

  initial Clk = 1'b0;
  always #6 Clk = ~Clk;

  function automatic exp_t observe();
    exp_t r;
    r.v = Out_valid;
    r.c = Carry_reg;
    r.o = Ovf_reg;
    r.s = Sum_reg;
    return r;
  endfunction

  // Apply operands and queue the result they must produce.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    exp_t       e;
    A    = a;
    B    = b;
    full = {1'b0, a} + {1'b0, b};
    e.v  = 1'b1;
    e.c  = full[W];
    e.s  = full[W-1:0];
    e.o  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t got;
    exp_t want;
    Rst = 1'b1;
    A   = 2'd3;
    B   = 2'd2;
    repeat (2) @(posedge Clk);
    #1;
    got = observe();
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_hold got v=%0b c=%0b o=%0b s=%0d want all zero", got.v, got.c, got.o, got.s);
    end
    sb.delete();
    Rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      drive(2'd3, 2'd2);
      @(posedge Clk);
      #1;
      if (sb.size() >= LAT) begin
        want = sb.pop_front();
        got  = observe();
        total++;
        if (got !== want || got !== {1'b1, 1'b1, 1'b1, 2'd1}) begin
          bad++;
          $display("FAIL reset_release got v=%0b c=%0b o=%0b s=%0d want v=1 c=1 o=1 s=1",
                   got.v, got.c, got.o, got.s);
        end
      end
    end
  endtask

  task automatic test_exhaustive();
    exp_t got;
    exp_t want;
    for (int i = 0; i < 16 + LAT - 1; i++) begin
      if (i < 16) drive(W'(i >> W), W'(i));
      else        drive('0, '0);
      @(posedge Clk);
      #1;
      if (sb.size() >= LAT) begin
        want = sb.pop_front();
        got  = observe();
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL exhaustive step=%0d got v=%0b c=%0b o=%0b s=%0d want v=%0b c=%0b o=%0b s=%0d",
                   i, got.v, got.c, got.o, got.s, want.v, want.c, want.o, want.s);
        end
      end
    end
  endtask

  task automatic test_max();
    exp_t got;
    exp_t want;
    for (int i = 0; i < LAT + 1; i++) begin
      drive(2'd3, 2'd3);
      @(posedge Clk);
      #1;
      if (sb.size() >= LAT) begin
        want = sb.pop_front();
        got  = observe();
        total++;
        if (got !== want || got.c !== 1'b1 || got.s !== 2'd2 || got.o !== 1'b0) begin
          bad++;
          $display("FAIL max_values got c=%0b o=%0b s=%0d want c=1 o=0 s=2", got.c, got.o, got.s);
        end
      end
    end
  endtask

  task automatic test_signed_ovf();
    exp_t got;
    exp_t want;
    for (int i = 0; i < LAT + 1; i++) begin
      drive(2'd1, 2'd1);
      @(posedge Clk);
      #1;
      if (sb.size() >= LAT) begin
        want = sb.pop_front();
        got  = observe();
        total++;
        if (got !== want || got.c !== 1'b0 || got.s !== 2'd2 || got.o !== 1'b1) begin
          bad++;
          $display("FAIL signed_ovf got c=%0b o=%0b s=%0d want c=0 o=1 s=2", got.c, got.o, got.s);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got;
    exp_t want;
    for (int i = 0; i < 14; i++) begin
      drive(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
      if (i == 6) Rst = 1'b1;
      @(posedge Clk);
      #1;
      if (i == 6) begin
        got = observe();
        total++;
        if (got !== '0) begin
          bad++;
          $display("FAIL midstream_reset got v=%0b c=%0b o=%0b s=%0d want all zero",
                   got.v, got.c, got.o, got.s);
        end
        sb.delete();
        Rst = 1'b0;
      end else if (sb.size() >= LAT) begin
        want = sb.pop_front();
        got  = observe();
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL back_to_back step=%0d got v=%0b c=%0b o=%0b s=%0d want v=%0b c=%0b o=%0b s=%0d",
                   i, got.v, got.c, got.o, got.s, want.v, want.c, want.o, want.s);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b1;
    A     = '0;
    B     = '0;
    test_reset();
    test_exhaustive();
    test_max();
    test_signed_ovf();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
